maj_rep_tx: RTL and testbench
=============================

Name: maj_rep_tx

Overview:
- Transmit side of the majority-vote link: serialises data words into a repetition-coded chip stream, each data bit emitted REP times in a row.
- The receiver recovers each bit with a REP-input majority gate, the same majority-gate style used in our MAJ networks.
- Sits between a word-level valid/ready producer and a chip-level valid/ready serial channel.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- REP, 3, repetitions per bit; must be odd and >=3 (elaboration error otherwise).
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first, 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  in_data valid.
- in_ready  output  1  word accepted when in_valid & in_ready at a rising edge.
- tx_chip  output  1  current coded chip.
- tx_valid  output  1  tx_chip valid.
- tx_ready  input  1  chip consumed when tx_valid & tx_ready at a rising edge.
- tx_sof  output  1  high with the first chip of a word.
- tx_eof  output  1  high with the last chip of a word.
- busy  output  1  word in flight (equals tx_valid).

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE; tx_chip=0, tx_valid=0, tx_sof=0, tx_eof=0, busy=0; shift reg, bit_idx, chip_idx cleared. in_ready=1 after reset.
- Registers:
  - shift reg DATA_W.
  - bit_idx, clog2(DATA_W) bits (min 1), 0..DATA_W-1.
  - chip_idx, clog2(REP) bits, 0..REP-1.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1.
  - On accept: load shift reg, bit_idx=0, chip_idx=0, go to SEND.
  - tx_valid=1 and first chip present on the next cycle (latency 1).
- SEND:
  - tx_chip = current head bit of the shift reg (MSB or LSB per MSB_FIRST).
  - tx_sof = (bit_idx==0 && chip_idx==0).
  - tx_eof = (bit_idx==DATA_W-1 && chip_idx==REP-1).
- Chip handshake:
  - On tx_valid & tx_ready: chip_idx++.
  - At chip_idx==REP-1: chip_idx wraps to 0, bit_idx++, shift reg shifts one position.
- Backpressure: with tx_valid=1 and tx_ready=0, tx_chip, tx_sof, tx_eof and all counters hold. tx_valid never drops mid-word.
- Word end, on the handshake of the eof chip:
  - If in_valid=1: in_ready=1 that cycle (combinational: in_ready = IDLE | (SEND & tx_eof & tx_ready)). The new word is loaded and the next word's sof chip follows with no gap.
  - Otherwise go to IDLE; tx_valid=0 next cycle.
- in_ready=0 for all other SEND cycles. in_data is sampled only on accept; later changes are ignored.
- Chips per word = DATA_W*REP exactly. With continuous tx_ready=1, a word occupies exactly DATA_W*REP consecutive cycles.
- Reset mid-word: word discarded, outputs to reset values immediately. No partial chips after deassert.
- Downstream rule (for the scoreboard): majority of each REP-chip group must equal the source bit.

Test Plan:
- Basic, DATA_W=8, REP=3, MSB_FIRST=1, tx_ready=1: send 0xA5 -> chips 111 000 111 000 000 111 000 111. tx_sof on chip 0, tx_eof on chip 23, tx_valid exactly 24 cycles, first chip 1 cycle after accept.
- LSB first, MSB_FIRST=0: send 0x01 -> chips 111 then 21 zeros.
- Backpressure: send 0x3C, tx_ready toggles 1,0,0,1,... pseudo-randomly. tx_chip/sof/eof stable while stalled; still exactly 24 accepted chips; decoded majority = 0x3C.
- Back-to-back: in_valid held high with 0xFF then 0x00, tx_ready=1 -> in_ready pulses in the eof cycle. 48 contiguous valid cycles: 24 ones, then 24 zeros, second sof immediately after first eof.
- Reset mid-word: assert rst_n=0 after 10 chips of 0xF0 -> tx_valid=0 asynchronously, in_ready=1 after release. Next word 0x0F is transmitted fully and correctly.
- REP=5, DATA_W=4: send 0x9 -> 20 chips 11111 00000 00000 11111. Each 5-chip group majority-decodes to 1001.

Source files
------------

// File: rtl/maj_rep_tx.sv
// maj_rep_tx -- transmit side of the majority-vote link.
//
// Serialises DATA_W-bit words into a repetition-coded chip stream. Each data
// bit is emitted REP times in a row, so the receiver can recover it with a
// REP-input majority gate.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_data   word to transmit, sampled only when accepted
//   in_valid  in_data valid
//   in_ready  word accepted when in_valid & in_ready at a rising edge
//   tx_chip   current coded chip
//   tx_valid  tx_chip valid (held for the whole word)
//   tx_ready  chip consumed when tx_valid & tx_ready at a rising edge
//   tx_sof    high with the first chip of a word
//   tx_eof    high with the last chip of a word
//   busy      word in flight (same as tx_valid)

module maj_rep_tx #(
   parameter int DATA_W    = 8,
   parameter int REP       = 3,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_chip,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_sof,
   output logic              tx_eof,
   output logic              busy
);

   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CHIP_W = $clog2(REP);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(REP - 1);

   // An even repetition count has no strict majority; refuse to elaborate.
   generate
      if (REP < 3 || (REP % 2) == 0) begin : g_bad_rep
         $error("maj_rep_tx: REP must be odd and >= 3");
      end
   endgenerate

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state,     nxt_state;
   logic [DATA_W-1:0]   shift_reg, nxt_shift;
   logic [BIT_W-1:0]    bit_idx,   nxt_bit;
   logic [CHIP_W-1:0]   chip_idx,  nxt_chip_idx;
   logic                nxt_tx_chip, nxt_tx_valid, nxt_tx_sof, nxt_tx_eof;
   logic                accept, fire;

   // Bit that goes on the line next, from whichever end leads.
   function automatic logic head(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   // The next word can only be taken while idle or on the handshake of the
   // current word's last chip, which keeps back-to-back words gap-free.
   assign in_ready = (state == IDLE) | ((state == SEND) & tx_eof & tx_ready);
   assign accept   = in_valid & in_ready;
   assign fire     = tx_valid & tx_ready;
   assign busy     = tx_valid;

   always_comb begin
      // NOTE: every signal written here gets a hold value first so that no
      // path leaves it unassigned and a latch is never inferred.
      nxt_state    = state;
      nxt_shift    = shift_reg;
      nxt_bit      = bit_idx;
      nxt_chip_idx = chip_idx;
      nxt_tx_chip  = tx_chip;
      nxt_tx_valid = tx_valid;
      nxt_tx_sof   = tx_sof;
      nxt_tx_eof   = tx_eof;

      if (accept) begin
         // Fresh word: first chip of its leading bit appears next cycle.
         nxt_state    = SEND;
         nxt_shift    = in_data;
         nxt_bit      = '0;
         nxt_chip_idx = '0;
         nxt_tx_chip  = head(in_data);
         nxt_tx_valid = 1'b1;
         nxt_tx_sof   = 1'b1;
         nxt_tx_eof   = 1'b0;
      end else if (fire) begin
         if (tx_eof) begin
            nxt_state    = IDLE;
            nxt_tx_chip  = 1'b0;
            nxt_tx_valid = 1'b0;
            nxt_tx_sof   = 1'b0;
            nxt_tx_eof   = 1'b0;
         end else begin
            if (chip_idx == CHIP_LAST) begin
               // Last repetition of this bit: move on to the next one.
               nxt_chip_idx = '0;
               nxt_bit      = bit_idx + 1'b1;
               nxt_shift    = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
            end else begin
               nxt_chip_idx = chip_idx + 1'b1;
            end
            nxt_tx_chip = head(nxt_shift);
            nxt_tx_sof  = 1'b0;
            nxt_tx_eof  = (nxt_bit == BIT_LAST) && (nxt_chip_idx == CHIP_LAST);
         end
      end
      // Without a handshake everything holds, which is exactly the
      // backpressure behaviour the channel expects.
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the shift register is ordinary state, not a memory array,
         // so it is cleared with the rest; a reset word leaves no residue.
         state     <= IDLE;
         shift_reg <= '0;
         bit_idx   <= '0;
         chip_idx  <= '0;
         tx_chip   <= 1'b0;
         tx_valid  <= 1'b0;
         tx_sof    <= 1'b0;
         tx_eof    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // same pre-edge values, independent of statement order.
         state     <= nxt_state;
         shift_reg <= nxt_shift;
         bit_idx   <= nxt_bit;
         chip_idx  <= nxt_chip_idx;
         tx_chip   <= nxt_tx_chip;
         tx_valid  <= nxt_tx_valid;
         tx_sof    <= nxt_tx_sof;
         tx_eof    <= nxt_tx_eof;
      end
   end

endmodule

// File: tb/tb_maj_rep_tx.sv
// tb_maj_rep_tx -- directed self-checking bench for maj_rep_tx.
//
// Three instances share one clock and reset:
//   a: DATA_W=8, REP=3, MSB first (basic, backpressure, back-to-back, reset)
//   b: DATA_W=8, REP=3, LSB first
//   c: DATA_W=4, REP=5, MSB first
// Chips are collected first-chip-in-MSB, so a hand-written hex constant reads
// left to right in transmit order.

module tb_maj_rep_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic [7:0] a_in_data;
   logic a_in_valid, a_in_ready, a_tx_chip, a_tx_valid, a_tx_ready, a_tx_sof, a_tx_eof, a_busy;
   logic [7:0] b_in_data;
   logic b_in_valid, b_in_ready, b_tx_chip, b_tx_valid, b_tx_ready, b_tx_sof, b_tx_eof, b_busy;
   logic [3:0] c_in_data;
   logic c_in_valid, c_in_ready, c_tx_chip, c_tx_valid, c_tx_ready, c_tx_sof, c_tx_eof, c_busy;

   maj_rep_tx #(.DATA_W(8), .REP(3), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .tx_chip(a_tx_chip), .tx_valid(a_tx_valid),
      .tx_ready(a_tx_ready), .tx_sof(a_tx_sof), .tx_eof(a_tx_eof), .busy(a_busy));

   maj_rep_tx #(.DATA_W(8), .REP(3), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .tx_chip(b_tx_chip), .tx_valid(b_tx_valid),
      .tx_ready(b_tx_ready), .tx_sof(b_tx_sof), .tx_eof(b_tx_eof), .busy(b_busy));

   maj_rep_tx #(.DATA_W(4), .REP(5), .MSB_FIRST(1'b1)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .tx_chip(c_tx_chip), .tx_valid(c_tx_valid),
      .tx_ready(c_tx_ready), .tx_sof(c_tx_sof), .tx_eof(c_tx_eof), .busy(c_busy));

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Majority-decode n collected chips in groups of rep, first group first.
   function automatic logic [7:0] decode(input logic [47:0] ch, input int n, input int rep);
      logic [7:0] w;
      int ones;
      w = '0;
      for (int g = 0; g < n / rep; g++) begin
         ones = 0;
         for (int k = 0; k < rep; k++) ones += int'(ch[n - 1 - g * rep - k]);
         w = {w[6:0], (ones > rep / 2)};
      end
      return w;
   endfunction

   // Statistics gathered by run_a for instance a.
   logic [47:0] chips;
   int n_chips, n_valid, first_valid, last_valid;
   int n_sof, sof_a, sof_b, n_eof, eof_a, eof_b;
   int accepts, acc_a, acc_b, stall_viol, rdy_viol;

   // Offer w0 (and w1 right after it when two=1) to instance a for max_cyc
   // cycles. bp=1 drives tx_ready from a fixed irregular pattern.
   task automatic run_a(input logic [7:0] w0, input bit two, input logic [7:0] w1,
                        input bit bp, input int max_cyc);
      logic [15:0] pat;
      logic prev_stall, p_chip, p_sof, p_eof;
      bit acc;
      pat = 16'b1011_0110_0101_1001;   // read from bit 0: 1,0,0,1,1,0,1,0,...
      chips = '0; n_chips = 0; n_valid = 0; first_valid = -1; last_valid = -1;
      n_sof = 0; sof_a = -1; sof_b = -1; n_eof = 0; eof_a = -1; eof_b = -1;
      accepts = 0; acc_a = -1; acc_b = -1; stall_viol = 0; rdy_viol = 0;
      prev_stall = 1'b0; p_chip = 1'b0; p_sof = 1'b0; p_eof = 1'b0;
      @(negedge clk);
      a_in_data  = w0;
      a_in_valid = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         a_tx_ready = bp ? pat[c % 16] : 1'b1;
         #1;
         if (prev_stall && (a_tx_valid !== 1'b1 || a_tx_chip !== p_chip ||
                            a_tx_sof !== p_sof || a_tx_eof !== p_eof))
            stall_viol++;
         if (a_tx_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = c;
            last_valid = c;
            if (a_in_ready !== (a_tx_eof & a_tx_ready)) rdy_viol++;
         end
         if (a_tx_valid && a_tx_ready) begin
            if (a_tx_sof) begin
               if (n_sof == 0) sof_a = n_chips; else sof_b = n_chips;
               n_sof++;
            end
            if (a_tx_eof) begin
               if (n_eof == 0) eof_a = n_chips; else eof_b = n_chips;
               n_eof++;
            end
            chips = {chips[46:0], a_tx_chip};
            n_chips++;
         end
         prev_stall = a_tx_valid && !a_tx_ready;
         p_chip = a_tx_chip; p_sof = a_tx_sof; p_eof = a_tx_eof;
         acc = a_in_valid && a_in_ready;
         if (acc) begin
            if (accepts == 0) acc_a = c; else acc_b = c;
            accepts++;
         end
         @(negedge clk);
         if (acc) begin
            if (two && accepts == 1) begin
               a_in_data = w1;
            end else begin
               a_in_valid = 1'b0;
               a_in_data  = ~w0;   // must not leak into the word in flight
            end
         end
      end
   endtask

   initial begin
      logic [47:0] ch;
      int n, sof_i, eof_i;

      rst_n = 1'b0;
      a_in_data = '0; a_in_valid = 1'b0; a_tx_ready = 1'b0;
      b_in_data = '0; b_in_valid = 1'b0; b_tx_ready = 1'b0;
      c_in_data = '0; c_in_valid = 1'b0; c_tx_ready = 1'b0;

      // ---- reset state ----
      #1;
      check("rst_tx_valid", a_tx_valid, 1'b0);
      check("rst_tx_chip",  a_tx_chip,  1'b0);
      check("rst_tx_sof",   a_tx_sof,   1'b0);
      check("rst_tx_eof",   a_tx_eof,   1'b0);
      check("rst_busy",     a_busy,     1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", a_in_ready, 1'b1);

      // ---- basic: 0xA5 MSB first, tx_ready=1 ----
      run_a(8'hA5, 1'b0, 8'h00, 1'b0, 30);
      check("basic_accept_cyc", acc_a, 0);
      check("basic_first_valid", first_valid, 1);
      check("basic_valid_cycles", n_valid, 24);
      check("basic_n_chips", n_chips, 24);
      check("basic_chips", chips[23:0], 24'hE381C7);
      check("basic_sof_idx", sof_a, 0);
      check("basic_eof_idx", eof_a, 23);
      check("basic_decode", decode(chips, 24, 3), 8'hA5);
      check("basic_in_ready", rdy_viol, 0);
      check("basic_idle_after", a_tx_valid, 1'b0);

      // ---- backpressure: 0x3C with irregular tx_ready ----
      run_a(8'h3C, 1'b0, 8'h00, 1'b1, 80);
      check("bp_n_chips", n_chips, 24);
      check("bp_chips", chips[23:0], 24'h03FFC0);
      check("bp_decode", decode(chips, 24, 3), 8'h3C);
      check("bp_stall_stable", stall_viol, 0);
      check("bp_valid_cycles", n_valid, 44);
      check("bp_sof_eof", {sof_a[7:0], eof_a[7:0]}, {8'd0, 8'd23});
      check("bp_in_ready", rdy_viol, 0);

      // ---- back-to-back: 0xFF then 0x00, in_valid held ----
      run_a(8'hFF, 1'b1, 8'h00, 1'b0, 60);
      check("b2b_accepts", accepts, 2);
      check("b2b_second_accept_cyc", acc_b, 24);
      check("b2b_valid_cycles", n_valid, 48);
      check("b2b_contiguous", last_valid - first_valid + 1, 48);
      check("b2b_chips", chips, 48'hFFFFFF_000000);
      check("b2b_sof", {sof_a[7:0], sof_b[7:0]}, {8'd0, 8'd24});
      check("b2b_eof", {eof_a[7:0], eof_b[7:0]}, {8'd23, 8'd47});
      check("b2b_in_ready", rdy_viol, 0);

      // ---- reset mid-word: 0xF0 cut after 10 chips, then 0x0F ----
      @(negedge clk);
      a_in_data = 8'hF0; a_in_valid = 1'b1; a_tx_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("mid_valid_before_rst", a_tx_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx_valid", a_tx_valid, 1'b0);
      check("mid_rst_outs", {a_tx_chip, a_tx_sof, a_tx_eof, a_busy}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid_in_ready", a_in_ready, 1'b1);
      check("mid_no_chips", a_tx_valid, 1'b0);
      run_a(8'h0F, 1'b0, 8'h00, 1'b0, 30);
      check("mid_next_chips", chips[23:0], 24'h000FFF);
      check("mid_next_n", n_chips, 24);
      check("mid_next_decode", decode(chips, 24, 3), 8'h0F);

      // ---- LSB first: 0x01 -> 111 then 21 zeros ----
      @(negedge clk);
      b_in_data = 8'h01; b_in_valid = 1'b1; b_tx_ready = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      b_in_data  = 8'hFE;
      ch = '0; n = 0; sof_i = -1; eof_i = -1;
      for (int c = 0; c < 30; c++) begin
         if (b_tx_valid && b_tx_ready) begin
            if (b_tx_sof) sof_i = n;
            if (b_tx_eof) eof_i = n;
            ch = {ch[46:0], b_tx_chip};
            n++;
         end
         @(negedge clk);
      end
      check("lsb_n_chips", n, 24);
      check("lsb_chips", ch[23:0], 24'hE00000);
      check("lsb_sof_eof", {sof_i[7:0], eof_i[7:0]}, {8'd0, 8'd23});

      // ---- REP=5, DATA_W=4: 0x9 -> 11111 00000 00000 11111 ----
      @(negedge clk);
      c_in_data = 4'h9; c_in_valid = 1'b1; c_tx_ready = 1'b1;
      @(negedge clk);
      c_in_valid = 1'b0;
      c_in_data  = 4'h6;
      ch = '0; n = 0; sof_i = -1; eof_i = -1;
      for (int c = 0; c < 30; c++) begin
         if (c_tx_valid && c_tx_ready) begin
            if (c_tx_sof) sof_i = n;
            if (c_tx_eof) eof_i = n;
            ch = {ch[46:0], c_tx_chip};
            n++;
         end
         @(negedge clk);
      end
      check("rep5_n_chips", n, 20);
      check("rep5_chips", ch[19:0], 20'hF801F);
      check("rep5_decode", decode(ch, 20, 5), 8'h09);
      check("rep5_sof_eof", {sof_i[7:0], eof_i[7:0]}, {8'd0, 8'd19});

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
